jk_bank_seq: RTL and testbench
==============================

Name: jk_bank_seq

Overview:
- Command-driven sequencer for a WIDTH-bit bank of JK flip-flops.
- Accepts one operation at a time over a valid/ready handshake.
- Drives each flop's J/K pair for a programmed number of clock cycles to load, clear, set, toggle, count up/down or shift the bank contents.
- Reads the bank's Q outputs back as q_in. The block contains no storage of bank data; the bank itself holds the state.

Parameters:
- WIDTH, 8, number of JK flops in the controlled bank.
- LEN_W, 8, width of the step-count field.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- n_rst  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  operation: 0 LOAD, 1 CLEAR, 2 SET, 3 TOGGLE, 4 CNT_UP, 5 CNT_DN, 6 SHIFT_L, 7 reserved (executes as hold).
- cmd_data  input  WIDTH  LOAD value / TOGGLE mask / SHIFT_L serial-in bit (bit 0).
- cmd_len  input  LEN_W  steps for CNT_UP/CNT_DN/SHIFT_L; 0 is treated as 1; ignored (forced to 1) for the other ops.
- q_in  input  WIDTH  Q outputs of the JK bank.
- j_out  output  WIDTH  J inputs to the bank.
- k_out  output  WIDTH  K inputs to the bank.
- busy  output  1  high in EXEC and DONE.
- done  output  1  one-cycle pulse after the last step.
- steps_left  output  LEN_W  remaining EXEC cycles, including the current one.

Behaviour:
- Reset (n_rst low at a clk edge):
  - state=IDLE, op/data/count registers cleared.
  - cmd_ready=1, busy=0, done=0, steps_left=0, j_out=k_out=0 (bank holds).
  - Reset mid-operation aborts the operation immediately; no done pulse. Bank contents are left as last updated.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op, data and effective length L (max(cmd_len,1) for count/shift ops, else 1), then go to EXEC with steps_left=L.
  - EXEC: cmd_ready=0. j_out/k_out are driven per op, combinationally from the latched op/data and the current q_in. At each edge steps_left decrements; when steps_left==1 the next state is DONE.
  - DONE: j_out=k_out=0, done=1 for exactly one cycle, cmd_ready=0, then IDLE.
  - Throughput: accept at cycle 0, EXEC cycles 1..L, DONE at cycle L+1, cmd_ready high again at cycle L+2.
- J/K encoding in EXEC, per bit i:
  - LOAD: J=data[i], K=~data[i].
  - CLEAR: J=0, K=1.
  - SET: J=1, K=0.
  - TOGGLE: J=K=data[i] (unmasked bits hold).
  - CNT_UP: J=K=AND of q_in[i-1:0]; bit 0 always toggles. Wraps all-ones -> 0.
  - CNT_DN: J=K=NOR of q_in[i-1:0]; bit 0 always toggles. Wraps 0 -> all-ones.
  - SHIFT_L: bit 0 takes J=data[0], K=~data[0]; bit i>0 takes J=q_in[i-1], K=~q_in[i-1]. MSB is discarded.
  - Reserved op: J=K=0 for one cycle.
- Outside EXEC: j_out=k_out=0 always, so the bank holds.
- cmd_valid while busy: ignored, not latched. The requester must hold it until accepted.
- cmd_* inputs are sampled only at the accept edge; changes during EXEC have no effect.

Test Plan:
- Reset, then LOAD data=0xA5 -> j_out=0xA5, k_out=0x5A for 1 cycle; bank reads 0xA5; done pulse at cycle 2; cmd_ready high at cycle 3.
- Bank=0xFD, CNT_UP len=4 -> bank sequence 0xFE, 0xFF, 0x00, 0x01; steps_left 4,3,2,1; one done pulse.
- Bank=0x01, CNT_DN len=3 -> 0x00, 0xFF, 0xFE; then TOGGLE mask=0x0F -> 0xF1.
- Bank=0x81, SHIFT_L len=2 with data[0]=1 -> 0x03, then 0x07; len=0 performs exactly one shift.
- Second cmd_valid held during EXEC -> not accepted until cycle L+2; then accepted with no lost cycle.
- n_rst low during CNT_UP step 2 of 5 -> next cycle IDLE, j_out=k_out=0, no done, bank frozen at partial value; CLEAR afterwards -> bank 0x00.

Source files
------------

// File: rtl/jk_bank_seq.sv
// Command sequencer for an external bank of JK flip-flops: decodes one operation at a time
// into per-bit J/K drive for a programmed number of cycles, reading the bank back on q_in.
module jk_bank_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] steps_left
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  typedef enum logic [2:0] {
    OpLoad   = 3'd0,
    OpClear  = 3'd1,
    OpSet    = 3'd2,
    OpToggle = 3'd3,
    OpCntUp  = 3'd4,
    OpCntDn  = 3'd5,
    OpShiftL = 3'd6,
    OpRsvd   = 3'd7
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] count_q, count_d;

  op_e              cmd_op_e;
  logic             cmd_multi;
  logic [LEN_W-1:0] eff_len;

  assign cmd_op_e  = op_e'(cmd_op);
  assign cmd_multi = (cmd_op_e == OpCntUp) || (cmd_op_e == OpCntDn) || (cmd_op_e == OpShiftL);
  assign eff_len   = (cmd_multi && (cmd_len != '0)) ? cmd_len : LEN_W'(1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op_e;
          data_d  = cmd_data;
          count_d = eff_len;
          state_d = StExec;
        end
      end
      StExec: begin
        count_d = count_q - LEN_W'(1);
        if (count_q == LEN_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= StIdle;
      op_q    <= OpLoad;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Counter carries: bit i toggles when all lower bits are 1 (up) or all are 0 (down).
  logic [WIDTH-1:0] carry_up, carry_dn;
  logic [WIDTH-1:0] low_mask;

  always_comb begin
    carry_up = '0;
    carry_dn = '0;
    low_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      low_mask    = (WIDTH'(1) << i) - WIDTH'(1);
      carry_up[i] = &(q_in | ~low_mask);
      carry_dn[i] = ~|(q_in & low_mask);
    end
  end

  // Drive is gated by n_rst so an abort freezes the bank on the cycle reset is asserted.
  always_comb begin
    j_out = '0;
    k_out = '0;
    if ((state_q == StExec) && n_rst) begin
      unique case (op_q)
        OpLoad: begin
          j_out = data_q;
          k_out = ~data_q;
        end
        OpClear: begin
          k_out = '1;
        end
        OpSet: begin
          j_out = '1;
        end
        OpToggle: begin
          j_out = data_q;
          k_out = data_q;
        end
        OpCntUp: begin
          j_out = carry_up;
          k_out = carry_up;
        end
        OpCntDn: begin
          j_out = carry_dn;
          k_out = carry_dn;
        end
        OpShiftL: begin
          j_out = {q_in[WIDTH-2:0], data_q[0]};
          k_out = ~{q_in[WIDTH-2:0], data_q[0]};
        end
        OpRsvd: begin
          j_out = '0;
          k_out = '0;
        end
        default: begin
          j_out = '0;
          k_out = '0;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q == StExec) || (state_q == StDone);
  assign done       = (state_q == StDone);
  assign steps_left = count_q;

endmodule

// File: tb/tb_jk_bank_seq.sv
// Bench for jk_bank_seq: models the JK bank locally and scores each step of every command
// against an expected-bank queue filled when the command is issued.
module tb_jk_bank_seq;

  logic       clk;
  logic       n_rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] cmd_len;
  logic [7:0] j_out;
  logic [7:0] k_out;
  logic       busy;
  logic       done;
  logic [7:0] steps_left;
  logic [7:0] bank = 8'h00;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_bank = 8'h00;
  logic [7:0] exp_q[$];

  jk_bank_seq #(.WIDTH(8), .LEN_W(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_len    (cmd_len),
    .q_in       (bank),
    .j_out      (j_out),
    .k_out      (k_out),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural JK bank
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      case ({j_out[i], k_out[i]})
        2'b10:   bank[i] <= 1'b1;
        2'b01:   bank[i] <= 1'b0;
        2'b11:   bank[i] <= ~bank[i];
        default: bank[i] <= bank[i];
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] next_bank(input logic [2:0] op, input logic [7:0] d,
                                           input logic [7:0] b);
    case (op)
      3'd0:    return d;
      3'd1:    return 8'h00;
      3'd2:    return 8'hff;
      3'd3:    return b ^ d;
      3'd4:    return b + 8'd1;
      3'd5:    return b - 8'd1;
      3'd6:    return {b[6:0], d[0]};
      default: return b;
    endcase
  endfunction

  // Issue one command, then score every EXEC step, the DONE cycle and the return to IDLE.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] data, input logic [7:0] len);
    int         l;
    int         waited;
    logic [7:0] b;
    logic [7:0] exp;
    logic [7:0] ej;
    logic [7:0] ek;
    logic       chk_jk;
    l = (op >= 3'd4 && op <= 3'd6) ? ((len == 8'd0) ? 1 : int'(len)) : 1;
    b = exp_bank;
    for (int s = 0; s < l; s++) begin
      b = next_bank(op, data, b);
      exp_q.push_back(b);
    end
    exp_bank = b;
    chk_jk = 1'b1;
    ej = 8'h00;
    ek = 8'h00;
    case (op)
      3'd0: begin ej = data;  ek = ~data; end
      3'd1: begin ej = 8'h00; ek = 8'hff; end
      3'd2: begin ej = 8'hff; ek = 8'h00; end
      3'd3: begin ej = data;  ek = data;  end
      3'd7: begin ej = 8'h00; ek = 8'h00; end
      default: chk_jk = 1'b0;
    endcase
    cmd_op = op;
    cmd_data = data;
    cmd_len = len;
    cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      step();
      waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait op=%0d: cmd_ready=%b required 1", op, cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
    cmd_data = ~data;
    cmd_len = 8'hff;
    for (int s = 0; s < l; s++) begin
      checks++;
      if (steps_left !== 8'(l - s) || busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL exec_status op=%0d step=%0d: steps_left=%0d busy=%b ready=%b done=%b required %0d 1 0 0",
                 op, s, steps_left, busy, cmd_ready, done, l - s);
      end
      if (s == 0 && chk_jk) begin
        checks++;
        if (j_out !== ej || k_out !== ek) begin
          failures++;
          $display("FAIL jk_drive op=%0d: j=%h k=%h required j=%h k=%h", op, j_out, k_out, ej, ek);
        end
      end
      step();
      exp = exp_q.pop_front();
      checks++;
      if (bank !== exp) begin
        failures++;
        $display("FAIL bank_step op=%0d step=%0d: bank=%h required %h", op, s, bank, exp);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0 || j_out !== 8'h00 ||
        k_out !== 8'h00 || steps_left !== 8'd0) begin
      failures++;
      $display("FAIL done_cycle op=%0d: done=%b busy=%b ready=%b j=%h k=%h steps=%0d required 1 1 0 00 00 0",
               op, done, busy, cmd_ready, j_out, k_out, steps_left);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || steps_left !== 8'd0 ||
        bank !== exp_bank) begin
      failures++;
      $display("FAIL idle_return op=%0d: done=%b busy=%b ready=%b steps=%0d bank=%h required 0 0 1 0 %h",
               op, done, busy, cmd_ready, steps_left, bank, exp_bank);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_data = 8'h00;
    cmd_len = 8'h00;
    repeat (3) step();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b busy=%b done=%b required 1 0 0", cmd_ready, busy, done);
    end
    checks++;
    if (steps_left !== 8'd0 || j_out !== 8'h00 || k_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_drive: steps=%0d j=%h k=%h required 0 00 00", steps_left, j_out, k_out);
    end
    n_rst = 1'b1;
    step();
    checks++;
    if (bank !== 8'h00 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: bank=%h ready=%b required 00 1", bank, cmd_ready);
    end
  endtask

  task automatic test_load();
    run_cmd(3'd0, 8'ha5, 8'd9);
  endtask

  task automatic test_count_up();
    run_cmd(3'd0, 8'hfd, 8'd0);
    run_cmd(3'd4, 8'h00, 8'd4);
  endtask

  task automatic test_count_dn_toggle();
    run_cmd(3'd0, 8'h01, 8'd0);
    run_cmd(3'd5, 8'h00, 8'd3);
    run_cmd(3'd3, 8'h0f, 8'd7);
  endtask

  task automatic test_shift();
    run_cmd(3'd0, 8'h81, 8'd0);
    run_cmd(3'd6, 8'h01, 8'd2);
    run_cmd(3'd6, 8'hfe, 8'd0);
  endtask

  task automatic test_set_reserved();
    run_cmd(3'd2, 8'h00, 8'd5);
    run_cmd(3'd7, 8'h3c, 8'd5);
    run_cmd(3'd1, 8'hff, 8'd5);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    run_cmd(3'd0, 8'h00, 8'd0);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'hf3);
    cmd_op = 3'd4;
    cmd_data = 8'h00;
    cmd_len = 8'd3;
    cmd_valid = 1'b1;
    step();
    cmd_op = 3'd3;
    cmd_data = 8'hf0;
    cmd_len = 8'd0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (cmd_ready !== 1'b0 || steps_left !== 8'(4 - c)) begin
        failures++;
        $display("FAIL b2b_exec cycle=%0d: ready=%b steps=%0d required 0 %0d",
                 c, cmd_ready, steps_left, 4 - c);
      end
      step();
      exp = exp_q.pop_front();
      checks++;
      if (bank !== exp) begin
        failures++;
        $display("FAIL b2b_bank cycle=%0d: bank=%h required %h", c, bank, exp);
      end
    end
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: done=%b ready=%b required 1 0", done, cmd_ready);
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready: ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || steps_left !== 8'd1 || j_out !== 8'hf0 || k_out !== 8'hf0) begin
      failures++;
      $display("FAIL b2b_second: busy=%b steps=%0d j=%h k=%h required 1 1 f0 f0",
               busy, steps_left, j_out, k_out);
    end
    step();
    exp = exp_q.pop_front();
    checks++;
    if (bank !== exp || done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_result: bank=%h done=%b required %h 1", bank, done, exp);
    end
    step();
    exp_bank = 8'hf3;
  endtask

  task automatic test_reset_abort();
    run_cmd(3'd0, 8'h10, 8'd0);
    cmd_op = 3'd4;
    cmd_data = 8'h00;
    cmd_len = 8'd5;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    checks++;
    if (bank !== 8'h12 || steps_left !== 8'd3) begin
      failures++;
      $display("FAIL abort_partial: bank=%h steps=%0d required 12 3", bank, steps_left);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if (j_out !== 8'h00 || k_out !== 8'h00) begin
      failures++;
      $display("FAIL abort_drive: j=%h k=%h required 00 00", j_out, k_out);
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || steps_left !== 8'd0 ||
        j_out !== 8'h00 || k_out !== 8'h00) begin
      failures++;
      $display("FAIL abort_idle: ready=%b busy=%b done=%b steps=%0d j=%h k=%h required 1 0 0 0 00 00",
               cmd_ready, busy, done, steps_left, j_out, k_out);
    end
    n_rst = 1'b1;
    step();
    checks++;
    if (bank !== 8'h12 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_frozen: bank=%h done=%b required 12 0", bank, done);
    end
    exp_bank = 8'h12;
    run_cmd(3'd1, 8'h00, 8'd0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_count_up();
    test_count_dn_toggle();
    test_shift();
    test_set_reserved();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
